// File: rtl/lc3_bus_arbiter.sv
// Round-robin arbiter for the shared LC-3 memory bus: 4 requesters, one-cold active-low grant.
// Optional forced-release timeout enabled by defining ARB_TIMEOUT_EN (uses HOLD_MAX).
module lc3_bus_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt_n,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_hold_range
        $error("lc3_bus_arbiter: HOLD_MAX must be in 2..256");
    end

    logic [1:0] state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       found;
    logic       timeout_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_q, hold_d;
    logic       timeout_q;
`endif

    // First requester at or after ptr, scanning upward with 2-bit wrap.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        cand   = ptr_q;
        for (int unsigned i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
`endif
        case (state_q)
            S_IDLE, S_GAP: begin
                if (|req) begin
                    state_d = S_GRANT;
                    owner_d = winner;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (!req[owner_q]) begin
                    state_d = S_GAP;
                    ptr_d   = owner_q + 2'd1;
                end
`ifdef ARB_TIMEOUT_EN
                // A drop on the expiry edge is taken above as a plain release.
                else if (hold_q == HOLD_LAST) begin
                    state_d   = S_GAP;
                    ptr_d     = owner_q + 2'd1;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = timeout_d;
    assign timeout        = 1'b0;
`endif

    assign busy   = (state_q == S_GRANT);
    assign gnt_id = owner_q;
    assign gnt_n  = busy ? ~(4'b0001 << owner_q) : 4'b1111;

endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// Self-checking bench for lc3_bus_arbiter: directed scenarios plus random requests
// compared every cycle against a cycle-level behavioural model of the arbitration rules.
module tb_lc3_bus_arbiter;

    localparam int HOLD_MAX = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt_n;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Model: who owns the bus, how many cycles it has held it, and where the scan starts.
    bit m_busy;
    bit m_to;
    int m_owner;
    int m_ptr;
    int m_held;

    lc3_bus_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt_n   (gnt_n),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_to    = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        if (m_busy) begin
            m_to = 1'b0;
            if (!r[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 4;
            end else if (TO_EN && m_held == HOLD_MAX) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 4;
                m_to   = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            m_to = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && r[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_busy  = 1'b1;
                    m_held  = 1;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] exp_gnt;
        exp_gnt = m_busy ? ~(4'b0001 << m_owner) : 4'b1111;
        check_eq("gnt_n", 32'(gnt_n), 32'(exp_gnt));
        check_eq("gnt_id", 32'(gnt_id), 32'(m_owner));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("timeout", 32'(timeout), 32'(m_to));
    endtask

    // Called at a negedge: drive, clock, update model, sample at the next negedge.
    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [9:0] bs;
        logic [9:0] ts;
        logic [3:0] r;

        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_eq("reset_gnt_n", 32'(gnt_n), 32'hF);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_gnt_id", 32'(gnt_id), 32'h0);
        check_eq("reset_timeout", 32'(timeout), 32'h0);

        // Rotation: everyone requests, each owner drops for one cycle after its grant.
        for (int i = 0; i < 5; i++) begin
            cycle(4'hF);
            check_eq("rot_id", 32'(gnt_id), 32'(i % 4));
            check_eq("rot_busy", 32'(busy), 32'h1);
            r = ~(4'b0001 << (i % 4));
            cycle(r);
            check_eq("rot_gap", 32'(gnt_n), 32'hF);
        end

        // Single requester 2.
        cycle(4'b0100);
        check_eq("single_gnt", 32'(gnt_n), 32'hB);
        check_eq("single_id", 32'(gnt_id), 32'h2);
        repeat (2) cycle(4'b0100);
        cycle(4'b0000);
        check_eq("single_drop", 32'(gnt_n), 32'hF);
        cycle(4'b0000);
        check_eq("single_idle", 32'(busy), 32'h0);

        // No preemption of owner 1 by requester 0.
        cycle(4'b0010);
        repeat (2) begin
            cycle(4'b0011);
            check_eq("nopre_gnt", 32'(gnt_n), 32'hD);
        end
        cycle(4'b0001);
        check_eq("nopre_gap", 32'(busy), 32'h0);
        cycle(4'b0001);
        check_eq("nopre_next", 32'(gnt_id), 32'h0);
        cycle(4'b0000);

        // Pointer wrap after owner 3 releases.
        cycle(4'b1000);
        check_eq("wrap_own3", 32'(gnt_id), 32'h3);
        cycle(4'b0011);
        cycle(4'b0011);
        check_eq("wrap_id", 32'(gnt_id), 32'h0);
        repeat (2) cycle(4'b0000);

        // One-cycle pulse, then sole requester re-raises after GAP.
        cycle(4'b0100);
        check_eq("pulse_busy", 32'(busy), 32'h1);
        cycle(4'b0000);
        check_eq("pulse_gap", 32'(busy), 32'h0);
        cycle(4'b0100);
        check_eq("reraise_gnt", 32'(gnt_n), 32'hB);
        repeat (2) cycle(4'b0000);

        // Sole requester holding: timeout pattern or indefinite hold.
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0001);
            bs[i] = busy;
            ts[i] = timeout;
        end
        if (TO_EN) begin
            check_eq("hold_busy_seq", 32'(bs), 32'b0111101111);
            check_eq("hold_to_seq", 32'(ts), 32'b1000010000);
        end else begin
            check_eq("hold_busy_seq", 32'(bs), 32'b1111111111);
            check_eq("hold_to_seq", 32'(ts), 32'b0000000000);
        end
        cycle(4'b0000);
        cycle(4'b0000);

        // Random request traffic with occasional bit toggles.
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            cycle(r);
        end

        // Asynchronous reset in the middle of a grant to requester 2.
        repeat (2) cycle(4'b0000);
        cycle(4'b0100);
        check_eq("pre_reset_gnt", 32'(gnt_n), 32'hB);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_gnt_n", 32'(gnt_n), 32'hF);
        check_eq("async_rst_busy", 32'(busy), 32'h0);
        check_eq("async_rst_id", 32'(gnt_id), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(4'b0110);
        check_eq("post_reset_id", 32'(gnt_id), 32'h1);
        repeat (3) cycle(4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
